// File: rtl/mem_arbiter.sv
// Arbitrates one shared single-port memory between an instruction-fetch and a data requester.
// Data normally wins ties; a fetch that has watched MAX_WAIT data grants go by takes the next tie.
module mem_arbiter #(
   parameter int unsigned MAX_WAIT = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        ireq,
   input  logic [31:0] iaddr,
   output logic        iresp_valid,
   output logic [31:0] iresp_data,
   input  logic        dreq,
   input  logic        dwrite,
   input  logic [31:0] daddr,
   input  logic [31:0] dwdata,
   output logic        dresp_valid,
   output logic [31:0] dresp_data,
   output logic        mreq,
   output logic        mwrite,
   output logic [31:0] maddr,
   output logic [31:0] mwdata,
   input  logic        mready,
   input  logic [31:0] mrdata,
   output logic        stall_i,
   output logic        stall_d,
   output logic [1:0]  dbg_state,
   output logic [2:0]  dbg_starve_cnt
);

   // Handshake: a requester raises req and holds it (with stable address/data) until it sees
   // its one-cycle resp_valid; the memory side finishes the access in any cycle with mready high.
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      I_BUSY = 2'd1,
      D_BUSY = 2'd2
   } state_t;

   localparam logic [2:0] MAX_WAIT_C = 3'(MAX_WAIT);

   state_t      state_q, state_d;
   logic [2:0]  starve_q, starve_d;
   logic        mreq_q, mreq_d;
   logic        mwrite_q, mwrite_d;
   logic [31:0] maddr_q, maddr_d;
   logic [31:0] mwdata_q, mwdata_d;
   logic        iresp_valid_q, iresp_valid_d;
   logic [31:0] iresp_data_q, iresp_data_d;
   logic        dresp_valid_q, dresp_valid_d;
   logic [31:0] dresp_data_q, dresp_data_d;
   logic        i_elig, d_elig;

   // A requester whose response is on the outputs this cycle is still holding req; skip it.
   assign i_elig = ireq & ~iresp_valid_q;
   assign d_elig = dreq & ~dresp_valid_q;

   always_comb begin
      state_d       = state_q;
      starve_d      = starve_q;
      mreq_d        = mreq_q;
      mwrite_d      = mwrite_q;
      maddr_d       = maddr_q;
      mwdata_d      = mwdata_q;
      iresp_valid_d = 1'b0;
      iresp_data_d  = 32'd0;
      dresp_valid_d = 1'b0;
      dresp_data_d  = 32'd0;
      case (state_q)
         IDLE: begin
            if (i_elig && (!d_elig || starve_q == MAX_WAIT_C)) begin
               state_d  = I_BUSY;
               starve_d = 3'd0;
               mreq_d   = 1'b1;
               mwrite_d = 1'b0;
               maddr_d  = iaddr;
               mwdata_d = 32'd0;
            end else if (d_elig) begin
               state_d  = D_BUSY;
               mreq_d   = 1'b1;
               mwrite_d = dwrite;
               maddr_d  = daddr;
               mwdata_d = dwdata;
               if (ireq && starve_q < MAX_WAIT_C) begin
                  starve_d = starve_q + 3'd1;
               end
            end
         end
         I_BUSY, D_BUSY: begin
            if (mready) begin
               state_d  = IDLE;
               mreq_d   = 1'b0;
               mwrite_d = 1'b0;
               maddr_d  = 32'd0;
               mwdata_d = 32'd0;
               if (state_q == I_BUSY) begin
                  iresp_valid_d = 1'b1;
                  iresp_data_d  = mrdata;
               end else begin
                  dresp_valid_d = 1'b1;
                  dresp_data_d  = mwrite_q ? 32'd0 : mrdata;
               end
            end
         end
         default: begin
            state_d  = IDLE;
            mreq_d   = 1'b0;
            mwrite_d = 1'b0;
            maddr_d  = 32'd0;
            mwdata_d = 32'd0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= IDLE;
         starve_q      <= 3'd0;
         mreq_q        <= 1'b0;
         mwrite_q      <= 1'b0;
         maddr_q       <= 32'd0;
         mwdata_q      <= 32'd0;
         iresp_valid_q <= 1'b0;
         iresp_data_q  <= 32'd0;
         dresp_valid_q <= 1'b0;
         dresp_data_q  <= 32'd0;
      end else begin
         state_q       <= state_d;
         starve_q      <= starve_d;
         mreq_q        <= mreq_d;
         mwrite_q      <= mwrite_d;
         maddr_q       <= maddr_d;
         mwdata_q      <= mwdata_d;
         iresp_valid_q <= iresp_valid_d;
         iresp_data_q  <= iresp_data_d;
         dresp_valid_q <= dresp_valid_d;
         dresp_data_q  <= dresp_data_d;
      end
   end

   assign mreq           = mreq_q;
   assign mwrite         = mwrite_q;
   assign maddr          = maddr_q;
   assign mwdata         = mwdata_q;
   assign iresp_valid    = iresp_valid_q;
   assign iresp_data     = iresp_data_q;
   assign dresp_valid    = dresp_valid_q;
   assign dresp_data     = dresp_data_q;
   assign stall_i        = ireq & ~iresp_valid_q;
   assign stall_d        = dreq & ~dresp_valid_q;
   assign dbg_state      = state_q;
   assign dbg_starve_cnt = starve_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a memory model answers bus accesses, and a negedge monitor
// checks every response and bus cycle against queues filled when each request is issued.
module tb_mem_arbiter;

   logic        clk;
   logic        reset;
   logic        ireq;
   logic [31:0] iaddr;
   logic        iresp_valid;
   logic [31:0] iresp_data;
   logic        dreq;
   logic        dwrite;
   logic [31:0] daddr;
   logic [31:0] dwdata;
   logic        dresp_valid;
   logic [31:0] dresp_data;
   logic        mreq;
   logic        mwrite;
   logic [31:0] maddr;
   logic [31:0] mwdata;
   logic        mready;
   logic [31:0] mrdata;
   logic        stall_i;
   logic        stall_d;
   logic [1:0]  dbg_state;
   logic [2:0]  dbg_starve_cnt;

   int checks = 0;
   int errors = 0;

   logic [31:0] exp_i_q[$];
   logic [31:0] exp_d_q[$];
   logic [64:0] exp_bus_q[$];

   bit          mem_auto;
   bit          man_ready;
   int          mem_delay;
   int          mem_cnt;
   logic [31:0] mem_xor;
   int          busy_n;
   logic [31:0] a;

   mem_arbiter #(.MAX_WAIT(4)) dut (
      .clk           (clk),
      .reset         (reset),
      .ireq          (ireq),
      .iaddr         (iaddr),
      .iresp_valid   (iresp_valid),
      .iresp_data    (iresp_data),
      .dreq          (dreq),
      .dwrite        (dwrite),
      .daddr         (daddr),
      .dwdata        (dwdata),
      .dresp_valid   (dresp_valid),
      .dresp_data    (dresp_data),
      .mreq          (mreq),
      .mwrite        (mwrite),
      .maddr         (maddr),
      .mwdata        (mwdata),
      .mready        (mready),
      .mrdata        (mrdata),
      .stall_i       (stall_i),
      .stall_d       (stall_d),
      .dbg_state     (dbg_state),
      .dbg_starve_cnt(dbg_starve_cnt)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #20000;
      $display("FAIL watchdog actual=still_running required=finished");
      $fatal(1, "simulation time limit reached");
   end

   task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Waits for the response, then drops the request on the following edge.
   task automatic wait_resp(input bit is_d, input int budget);
      bit seen;
      seen = 1'b0;
      for (int n = 0; n < budget && !seen; n++) begin
         @(negedge clk);
         seen = is_d ? dresp_valid : iresp_valid;
      end
      chk(is_d ? "dresp_arrived" : "iresp_arrived", 65'(seen), 65'd1);
      tick();
      if (is_d) dreq = 1'b0;
      else ireq = 1'b0;
   endtask

   // memory model: data read = address ^ mem_xor, completes after mem_delay wait cycles
   initial begin
      mready  = 1'b0;
      mrdata  = 32'd0;
      mem_cnt = 0;
      forever begin
         @(posedge clk);
         #1;
         if (!mem_auto) begin
            mready  = man_ready;
            mrdata  = 32'hFEED_0000;
            mem_cnt = 0;
         end else if (mreq) begin
            if (mem_cnt >= mem_delay) begin
               mready = 1'b1;
               mrdata = maddr ^ mem_xor;
            end else begin
               mready = 1'b0;
               mrdata = 32'hBAD0_0000;
               mem_cnt++;
            end
         end else begin
            mready  = 1'b0;
            mrdata  = 32'd0;
            mem_cnt = 0;
         end
      end
   end

   // scoreboard monitor
   always @(negedge clk) begin
      if (!reset) begin
         chk("one_resp_at_a_time", 65'(iresp_valid & dresp_valid), 65'd0);
         if (iresp_valid) begin
            chk("iresp_expected", 65'(exp_i_q.size() != 0), 65'd1);
            if (exp_i_q.size() != 0) chk("iresp_data", 65'(iresp_data), 65'(exp_i_q.pop_front()));
         end else begin
            chk("iresp_idle_zero", 65'(iresp_data), 65'd0);
         end
         if (dresp_valid) begin
            chk("dresp_expected", 65'(exp_d_q.size() != 0), 65'd1);
            if (exp_d_q.size() != 0) chk("dresp_data", 65'(dresp_data), 65'(exp_d_q.pop_front()));
         end else begin
            chk("dresp_idle_zero", 65'(dresp_data), 65'd0);
         end
         if (mreq) begin
            chk("bus_expected", 65'(exp_bus_q.size() != 0), 65'd1);
            if (exp_bus_q.size() != 0) begin
               chk("bus_fields", {mwrite, maddr, mwdata}, exp_bus_q[0]);
               if (mready) void'(exp_bus_q.pop_front());
            end
         end else begin
            chk("bus_idle_zero", {mwrite, maddr, mwdata}, 65'd0);
         end
      end
   end

   initial begin
      reset = 1'b1; ireq = 1'b0; iaddr = '0; dreq = 1'b0; dwrite = 1'b0;
      daddr = '0; dwdata = '0; mem_auto = 1'b1; man_ready = 1'b0;
      mem_delay = 0; mem_xor = '0; busy_n = 0; a = '0;

      // reset state; stall_i still follows its equation while reset holds
      repeat (2) @(negedge clk);
      chk("rst_mreq", 65'(mreq), 65'd0);
      chk("rst_state", 65'(dbg_state), 65'd0);
      chk("rst_starve", 65'(dbg_starve_cnt), 65'd0);
      chk("rst_iresp", 65'(iresp_valid), 65'd0);
      ireq = 1'b1;
      #1;
      chk("rst_stall_i", 65'(stall_i), 65'd1);
      tick();
      chk("rst_no_grant", 65'(mreq), 65'd0);
      ireq = 1'b0;
      tick();
      reset = 1'b0;

      // single fetch, 2-cycle latency
      mem_xor = 32'hDEAD_BFEF;
      ireq = 1'b1; iaddr = 32'h100;
      exp_bus_q.push_back({1'b0, 32'h100, 32'h0});
      exp_i_q.push_back(32'hDEAD_BEEF);
      @(negedge clk);
      chk("f_stall_wait", 65'(stall_i), 65'd1);
      chk("f_pre_mreq", 65'(mreq), 65'd0);
      @(negedge clk);
      chk("f_mreq", 65'(mreq), 65'd1);
      chk("f_maddr", 65'(maddr), 65'h100);
      chk("f_state", 65'(dbg_state), 65'd1);
      @(negedge clk);
      chk("f_iresp_valid", 65'(iresp_valid), 65'd1);
      chk("f_stall_done", 65'(stall_i), 65'd0);
      chk("f_mreq_done", 65'(mreq), 65'd0);
      tick();
      ireq = 1'b0;
      repeat (3) @(negedge clk);
      chk("f_starve", 65'(dbg_starve_cnt), 65'd0);

      // simultaneous requests: data first, fetch in the data-response cycle
      tick();
      mem_xor = '0;
      ireq = 1'b1; iaddr = 32'h200;
      dreq = 1'b1; dwrite = 1'b0; daddr = 32'h300;
      exp_bus_q.push_back({1'b0, 32'h300, 32'h0});
      exp_bus_q.push_back({1'b0, 32'h200, 32'h0});
      exp_d_q.push_back(32'h300);
      exp_i_q.push_back(32'h200);
      fork
         wait_resp(1'b0, 20);
         wait_resp(1'b1, 20);
         begin
            for (int n = 0; n < 20; n++) begin
               @(negedge clk);
               if (iresp_valid) break;
               chk("sim_stall_i", 65'(stall_i), 65'd1);
               if (n == 1) chk("sim_starve_one", 65'(dbg_starve_cnt), 65'd1);
            end
         end
      join
      chk("sim_starve_end", 65'(dbg_starve_cnt), 65'd0);

      // store with 3 memory wait cycles
      tick();
      mem_delay = 3; mem_xor = 32'h1234_5678;
      dreq = 1'b1; dwrite = 1'b1; daddr = 32'h2000; dwdata = 32'h55;
      exp_bus_q.push_back({1'b1, 32'h2000, 32'h55});
      exp_d_q.push_back(32'h0);
      busy_n = 0;
      fork
         wait_resp(1'b1, 30);
         begin
            for (int n = 0; n < 30; n++) begin
               @(negedge clk);
               if (dresp_valid) break;
               if (mreq) busy_n++;
            end
         end
      join
      chk("st_busy_cycles", 65'(busy_n), 65'd4);
      mem_delay = 0; mem_xor = '0; dwrite = 1'b0; dwdata = '0;

      // load, then request dropped: no second bus access
      dreq = 1'b1; daddr = 32'h44;
      exp_bus_q.push_back({1'b0, 32'h44, 32'h0});
      exp_d_q.push_back(32'h44);
      wait_resp(1'b1, 20);
      for (int n = 0; n < 4; n++) begin
         @(negedge clk);
         chk("ng_mreq", 65'(mreq), 65'd0);
      end
      chk("ng_state", 65'(dbg_state), 65'd0);

      // starvation: fetch withdrawn in each data-response cycle so both meet again in IDLE
      tick();
      for (int k = 0; k < 4; k++) begin
         a = 32'h500 + 32'(4 * k);
         ireq = 1'b1; iaddr = 32'h400;
         dreq = 1'b1; daddr = a;
         exp_bus_q.push_back({1'b0, a, 32'h0});
         exp_d_q.push_back(a);
         tick();
         ireq = 1'b0;
         wait_resp(1'b1, 20);
         chk("sv_starve_count", 65'(dbg_starve_cnt), 65'(k + 1));
         tick();
      end
      ireq = 1'b1; iaddr = 32'h400;
      dreq = 1'b1; daddr = 32'h510;
      exp_bus_q.push_back({1'b0, 32'h400, 32'h0});
      exp_bus_q.push_back({1'b0, 32'h510, 32'h0});
      exp_i_q.push_back(32'h400);
      exp_d_q.push_back(32'h510);
      fork
         wait_resp(1'b0, 20);
         wait_resp(1'b1, 20);
         begin
            @(negedge clk);
            @(negedge clk);
            chk("sv_fetch_granted", 65'(dbg_state), 65'd1);
            chk("sv_starve_clear", 65'(dbg_starve_cnt), 65'd0);
         end
      join
      chk("sv_starve_final", 65'(dbg_starve_cnt), 65'd1);

      // reset in the middle of a data access
      tick();
      mem_auto = 1'b0; man_ready = 1'b0;
      dreq = 1'b1; dwrite = 1'b0; daddr = 32'h600;
      exp_bus_q.push_back({1'b0, 32'h600, 32'h0});
      @(negedge clk);
      @(negedge clk);
      chk("rm_state_busy", 65'(dbg_state), 65'd2);
      chk("rm_mreq_busy", 65'(mreq), 65'd1);
      #2;
      reset = 1'b1;
      #1;
      chk("rm_mreq_async", 65'(mreq), 65'd0);
      chk("rm_maddr_async", 65'(maddr), 65'd0);
      chk("rm_state_async", 65'(dbg_state), 65'd0);
      chk("rm_stall_d", 65'(stall_d), 65'd1);
      exp_bus_q.delete();
      man_ready = 1'b1;
      repeat (2) tick();
      dreq = 1'b0;
      reset = 1'b0;
      for (int n = 0; n < 3; n++) begin
         @(negedge clk);
         chk("rm_no_dresp", 65'(dresp_valid), 65'd0);
         chk("rm_no_mreq", 65'(mreq), 65'd0);
         man_ready = 1'b0;
      end
      chk("rm_state_idle", 65'(dbg_state), 65'd0);

      // arbitration resumes after reset
      tick();
      mem_auto = 1'b1;
      ireq = 1'b1; iaddr = 32'h700;
      exp_bus_q.push_back({1'b0, 32'h700, 32'h0});
      exp_i_q.push_back(32'h700);
      @(negedge clk);
      @(negedge clk);
      chk("rs_mreq", 65'(mreq), 65'd1);
      wait_resp(1'b0, 20);

      repeat (3) @(negedge clk);
      chk("end_i_queue", 65'(exp_i_q.size()), 65'd0);
      chk("end_d_queue", 65'(exp_d_q.size()), 65'd0);
      chk("end_bus_queue", 65'(exp_bus_q.size()), 65'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
